// File: rtl/serial_pkg.sv
// Framing constants shared by both ends of the one-bit-per-clock serial link.
// Holds the state encodings and line levels so transmitter and receiver agree.
// No logic; types and constants only.
package serial_pkg;

   // State encodings used by the framing FSMs.
   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] START  = 3'd1;
   localparam logic [2:0] DATA   = 3'd2;
   localparam logic [2:0] PARITY = 3'd3;
   localparam logic [2:0] STOP   = 3'd4;

   typedef enum logic [2:0] {
      S_IDLE   = IDLE,
      S_START  = START,
      S_DATA   = DATA,
      S_PARITY = PARITY,
      S_STOP   = STOP
   } state_t;

   // Line levels for the framing bits.
   localparam logic IDLE_LEVEL  = 1'b1;
   localparam logic START_LEVEL = 1'b0;
   localparam logic STOP_LEVEL  = 1'b1;

endpackage

// File: rtl/serial_transmitter.sv
// Serial frame transmitter: start bit, DATA_BITS data bits LSB first, optional parity, one stop bit.
// Latency: byte accepted at edge E0 puts the start bit on the line after edge E1.
// Backpressure: ready is low while the one-entry holding register is full; valid is ignored then.
module serial_transmitter
   import serial_pkg::*;
#(
   parameter int DATA_BITS  = 8,
   parameter bit PARITY_EN  = 1'b0,
   parameter bit PARITY_ODD = 1'b0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [DATA_BITS-1:0] data_in,
   input  logic                 valid,
   output logic                 ready,
   output logic                 out,
   output logic                 busy,
   output logic                 done
);

   localparam int                CNT_W    = $clog2(DATA_BITS);
   localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_BITS - 1);

   state_t               state;
   logic [DATA_BITS-1:0] hold;
   logic                 hold_valid;
   logic [DATA_BITS-1:0] shift;
   logic [CNT_W-1:0]     bit_cnt;
   logic                 parity;
   logic                 load;

   // The holding register drains into the shifter only between frames: from IDLE,
   // or straight out of STOP so back-to-back frames have no idle gap.
   assign load  = hold_valid && (state == S_IDLE || state == S_STOP);
   assign ready = !hold_valid;

   // Line, busy and done decode purely from registered state; no input reaches them.
   always_comb begin
      out  = IDLE_LEVEL;
      busy = (state != S_IDLE);
      done = 1'b0;
      case (state)
         S_START:  out = START_LEVEL;
         S_DATA:   out = shift[0];
         S_PARITY: out = parity ^ PARITY_ODD;
         S_STOP: begin
            out  = STOP_LEVEL;
            done = 1'b1;
         end
         default:  out = IDLE_LEVEL;
      endcase
   end

   // Holding register, shifter, bit counter, parity accumulator and frame FSM.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         hold       <= '0;
         hold_valid <= 1'b0;
         shift      <= '0;
         bit_cnt    <= '0;
         parity     <= 1'b0;
      end else begin
         // Accept and load never coincide: load needs hold_valid, accept needs it clear.
         if (valid && !hold_valid) begin
            hold       <= data_in;
            hold_valid <= 1'b1;
         end

         if (load) begin
            shift      <= hold;
            hold_valid <= 1'b0;
            bit_cnt    <= '0;
            parity     <= 1'b0;
            state      <= S_START;
         end else begin
            case (state)
               S_IDLE:  state <= S_IDLE;
               S_START: state <= S_DATA;
               S_DATA: begin
                  shift  <= shift >> 1;
                  parity <= parity ^ shift[0];
                  if (bit_cnt == LAST_BIT) begin
                     bit_cnt <= '0;
                     state   <= PARITY_EN ? S_PARITY : S_STOP;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end
               S_PARITY: state <= S_STOP;
               S_STOP:   state <= S_IDLE;
               default:  state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_serial_transmitter.sv
// Bench for serial_transmitter: three instances (no parity, even parity, odd parity).
// Fixed frames come from a table of expected line sequences; a behavioural
// receiver on instance 0 decodes every frame and checks it against a byte scoreboard.
module tb_serial_transmitter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset;
   logic [2:0] valid_v;
   logic [7:0] data_v [3];
   wire  [2:0] ready_v, out_v, busy_v, done_v;

   int   nvec = 0;
   int   nmis = 0;
   int   rx_cnt = 0;
   bit   mon_en = 1'b0;
   logic [7:0] exp_q [$];

   serial_transmitter #(.DATA_BITS(8), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) dut_np (
      .clk(clk), .reset(reset), .data_in(data_v[0]), .valid(valid_v[0]),
      .ready(ready_v[0]), .out(out_v[0]), .busy(busy_v[0]), .done(done_v[0]));

   serial_transmitter #(.DATA_BITS(8), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut_pe (
      .clk(clk), .reset(reset), .data_in(data_v[1]), .valid(valid_v[1]),
      .ready(ready_v[1]), .out(out_v[1]), .busy(busy_v[1]), .done(done_v[1]));

   serial_transmitter #(.DATA_BITS(8), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) dut_po (
      .clk(clk), .reset(reset), .data_in(data_v[2]), .valid(valid_v[2]),
      .ready(ready_v[2]), .out(out_v[2]), .busy(busy_v[2]), .done(done_v[2]));

   typedef struct {
      int         dut;
      logic [7:0] data;
      int         len;
      logic [0:10] bits;   // expected line value per cycle, first bit at index 0
   } vec_t;

   vec_t tbl [9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nmis++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_rx(input int target, input int budget);
      for (int c = 0; c < budget && rx_cnt < target; c++) tick();
      chk("rx_count", rx_cnt, target);
   endtask

   // Offer one byte to instance k and check the whole frame cycle by cycle.
   task automatic send_frame(input int k, input logic [7:0] d, input logic [0:10] bits, input int len);
      chk($sformatf("pre_ready[%0d]", k), ready_v[k], 1);
      valid_v[k] = 1'b1;
      data_v[k]  = d;
      if (k == 0) exp_q.push_back(d);
      tick();
      valid_v[k] = 1'b0;
      chk($sformatf("acc_ready[%0d]", k), ready_v[k], 0);
      chk($sformatf("acc_out[%0d]", k), out_v[k], 1);
      chk($sformatf("acc_busy[%0d]", k), busy_v[k], 0);
      tick();
      for (int i = 0; i < len; i++) begin
         chk($sformatf("frame_out[%0d] %0h bit%0d", k, d, i), out_v[k], bits[i]);
         chk($sformatf("frame_busy[%0d] bit%0d", k, i), busy_v[k], 1);
         chk($sformatf("frame_done[%0d] bit%0d", k, i), done_v[k], (i == len - 1) ? 1 : 0);
         tick();
      end
      chk($sformatf("post_out[%0d]", k), out_v[k], 1);
      chk($sformatf("post_busy[%0d]", k), busy_v[k], 0);
      chk($sformatf("post_done[%0d]", k), done_v[k], 0);
      chk($sformatf("post_ready[%0d]", k), ready_v[k], 1);
   endtask

   // Behavioural receiver on instance 0: finds a start bit, gathers 8 bits LSB
   // first, requires the stop bit with done, and compares against the scoreboard.
   initial begin
      logic [7:0] b;
      forever begin
         @(negedge clk);
         if (mon_en && !reset && out_v[0] === 1'b0) begin
            chk("rx_busy_start", busy_v[0], 1);
            chk("rx_done_start", done_v[0], 0);
            for (int i = 0; i < 8; i++) begin
               @(negedge clk);
               b[i] = out_v[0];
               chk("rx_done_data", done_v[0], 0);
            end
            @(negedge clk);
            chk("rx_stop", out_v[0], 1);
            chk("rx_done_stop", done_v[0], 1);
            if (exp_q.size() == 0) begin
               chk("rx_unexpected_frame", {24'd0, b}, 32'hFFFF_FFFF);
            end else begin
               chk("rx_byte", b, exp_q.pop_front());
            end
            rx_cnt++;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [0:19] bb;
      logic [0:11] rpat;
      int          base;
      int          sent;

      tbl[0] = '{0, 8'h81, 10, 11'b01000000110};
      tbl[1] = '{0, 8'hA5, 10, 11'b01010010110};
      tbl[2] = '{0, 8'h00, 10, 11'b00000000010};
      tbl[3] = '{0, 8'hFF, 10, 11'b01111111110};
      tbl[4] = '{0, 8'h3C, 10, 11'b00011110010};
      tbl[5] = '{1, 8'h07, 11, 11'b01110000011};
      tbl[6] = '{2, 8'h07, 11, 11'b01110000001};
      tbl[7] = '{1, 8'h01, 11, 11'b01000000011};
      tbl[8] = '{2, 8'h03, 11, 11'b01100000011};

      // Reset with valid asserted: nothing may be accepted.
      reset   = 1'b1;
      valid_v = 3'b111;
      for (int k = 0; k < 3; k++) data_v[k] = 8'hEE;
      repeat (3) tick();
      reset   = 1'b0;
      valid_v = 3'b000;
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("rst_out[%0d]", k), out_v[k], 1);
         chk($sformatf("rst_ready[%0d]", k), ready_v[k], 1);
         chk($sformatf("rst_busy[%0d]", k), busy_v[k], 0);
         chk($sformatf("rst_done[%0d]", k), done_v[k], 0);
      end
      repeat (3) tick();
      chk("rst_no_accept_busy", busy_v[0], 0);
      chk("rst_no_accept_out", out_v[0], 1);

      // Reset during data bit 3 of 0x3C while 0x55 is pending.
      valid_v[0] = 1'b1;
      data_v[0]  = 8'h3C;
      tick();
      data_v[0]  = 8'h55;
      tick();
      chk("rm_ready_start", ready_v[0], 1);
      tick();
      valid_v[0] = 1'b0;
      chk("rm_ready_pending", ready_v[0], 0);
      repeat (3) tick();
      chk("rm_bit3", out_v[0], 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("rm_out", out_v[0], 1);
      chk("rm_ready", ready_v[0], 1);
      chk("rm_busy", busy_v[0], 0);
      chk("rm_done", done_v[0], 0);
      for (int i = 0; i < 15; i++) begin
         tick();
         chk("rm_idle_out", out_v[0], 1);
         chk("rm_idle_busy", busy_v[0], 0);
         chk("rm_idle_done", done_v[0], 0);
      end
      mon_en = 1'b1;

      // Fixed frames, including the send of 0x81 right after the reset.
      for (int v = 0; v < 9; v++) send_frame(tbl[v].dut, tbl[v].data, tbl[v].bits, tbl[v].len);

      // Back-to-back: 0x00 then 0xFF with valid held high.
      bb = 20'b0_00000000_1_0_11111111_1;
      valid_v[0] = 1'b1;
      data_v[0]  = 8'h00;
      exp_q.push_back(8'h00);
      tick();
      data_v[0]  = 8'hFF;
      chk("b2b_ready_acc", ready_v[0], 0);
      tick();
      exp_q.push_back(8'hFF);
      for (int i = 0; i < 20; i++) begin
         chk($sformatf("b2b_out bit%0d", i), out_v[0], bb[i]);
         chk($sformatf("b2b_busy bit%0d", i), busy_v[0], 1);
         chk($sformatf("b2b_done bit%0d", i), done_v[0], (i == 9 || i == 19) ? 1 : 0);
         chk($sformatf("b2b_ready bit%0d", i), ready_v[0], (i == 0 || i >= 10) ? 1 : 0);
         tick();
         if (i == 0) valid_v[0] = 1'b0;
      end
      chk("b2b_post_out", out_v[0], 1);
      chk("b2b_post_busy", busy_v[0], 0);

      // Backpressure: valid held with data changing every cycle.
      base = rx_cnt;
      rpat = 12'b010000000001;
      valid_v[0] = 1'b1;
      data_v[0]  = 8'h5A;
      chk("bp_ready0", ready_v[0], 1);
      exp_q.push_back(8'h5A);
      tick();
      for (int j = 0; j < 12; j++) begin
         chk($sformatf("bp_ready E%0d", j), ready_v[0], rpat[j]);
         data_v[0] = 8'($urandom);
         if (ready_v[0]) exp_q.push_back(data_v[0]);
         tick();
      end
      valid_v[0] = 1'b0;
      chk("bp_ready_end", ready_v[0], 0);
      wait_rx(base + 3, 80);

      // Random loopback: 25 bytes offered as soon as ready, 25 with random gaps.
      base = rx_cnt;
      sent = 0;
      for (int c = 0; c < 4000 && sent < 50; c++) begin
         if (ready_v[0] && (sent < 25 || $urandom_range(0, 9) == 0)) begin
            valid_v[0] = 1'b1;
            data_v[0]  = 8'($urandom);
            exp_q.push_back(data_v[0]);
            sent++;
         end else begin
            valid_v[0] = 1'b0;
         end
         tick();
      end
      valid_v[0] = 1'b0;
      chk("rand_sent", sent, 50);
      wait_rx(base + 50, 200);
      repeat (3) tick();
      chk("scoreboard_empty", exp_q.size(), 0);
      chk("final_idle_out", out_v[0], 1);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule

// File: doc/serial_transmitter.md
Name: serial_transmitter

Overview:
- Serial frame transmitter: transmit half of the team's one-bit-per-clock serial link.
- Takes parallel bytes through a valid/ready handshake and drives a start bit (0), DATA_BITS data bits LSB first, an optional parity bit and one stop bit (1) on `out`.
- The line idles high.
- A one-entry holding register allows back-to-back frames with no idle gap, so the serial receiver's stop→start path is exercised.

Parameters:
- DATA_BITS, 8, data bits per frame; legal range 5-8.
- PARITY_EN, 0, 1 inserts a parity bit between the last data bit and the stop bit.
- PARITY_ODD, 0, with PARITY_EN=1: 0 = even parity, 1 = odd parity.

Ports:
- clk  input  1  clock; every register updates on posedge clk.
- reset  input  1  synchronous, active-high reset.
- data_in  input  DATA_BITS  byte to send; sampled when valid && ready.
- valid  input  1  producer offers data_in.
- ready  output  1  holding register empty; equals !hold_valid.
- out  output  1  serial line; 1 when idle.
- busy  output  1  1 whenever state != IDLE.
- done  output  1  high for exactly the stop-bit cycle of each frame.

Behaviour:
- Reset (synchronous, active-high, one clock; takes priority over everything):
  - state=IDLE, hold_valid=0, bit counter=0, shift register=0.
  - Outputs next cycle: out=1, ready=1, busy=0, done=0.
- Reset mid-frame: the frame is abandoned and the pending byte is discarded. out returns to 1 in the cycle after the reset edge; there is no partial stop bit.
- Accept: on a clock edge with valid && ready, hold <= data_in and hold_valid <= 1.
  - While ready=0, valid is ignored and data_in is not sampled. The producer holds valid.
- Output timing: out, busy and done are decoded only from registered state. There is no combinational path from any input to these outputs.
- States:
  - IDLE: out=1. If hold_valid: shift <= hold, hold_valid <= 0, counter <= 0, parity accumulator <= 0; go to START.
  - START: out=0, for 1 cycle; then go to DATA.
  - DATA: out=shift[0]; each cycle shift >>= 1, counter += 1, parity ^= shift[0]. When counter == DATA_BITS-1, go to PARITY if PARITY_EN, else STOP.
  - PARITY: out = parity ^ PARITY_ODD, for 1 cycle; then go to STOP.
  - STOP: out=1, done=1, for 1 cycle.
    - If hold_valid: perform the IDLE load action and go directly to START, with no idle cycle.
    - Otherwise go to IDLE.
- Latency: accept at edge E0 → START entered at edge E1, so out=0 during the cycle after E1.
- Frame length: 2 + DATA_BITS + PARITY_EN cycles (10 for the defaults).
- ready behaviour:
  - Goes low the cycle after an accept.
  - Returns high the cycle after hold transfers to shift.
  - A new byte can therefore be accepted during START of the current frame.
- Simultaneous transfer and accept cannot occur: transfer needs hold_valid=1, and then ready=0.
- Counter width: $clog2(DATA_BITS). Counter and state never wrap outside the legal states. Any unused state encoding goes to IDLE on the next edge.
- valid asserted during reset: ignored; the first accept is possible on the edge after reset deasserts.

Decomposition:
- Shared package `serial_pkg`: state encodings (IDLE, START, DATA, PARITY, STOP as 3-bit localparams), IDLE_LEVEL=1, START_LEVEL=0, STOP_LEVEL=1. Shared with the serial receiver so both ends agree on framing.
- Single module; no sub-module. The holding register and shifter stay inline.

Test Plan:
- Single frame: reset, then send 0xA5 with defaults → out = 0,1,0,1,0,0,1,0,1,1 over 10 cycles starting one cycle after the accept edge.
  - done high only on the last of those cycles; busy high for all 10 cycles; out=1 afterwards.
- Back-to-back: send 0x00 immediately followed by 0xFF (valid held high) → the second accept occurs during START of frame 1.
  - After frame 1's stop bit, the start bit of frame 2 follows with no idle cycle: 0,00000000,1,0,11111111,1.
- Backpressure: valid held high with changing data_in while ready=0 → only the byte present on the accept edge is transmitted; ready pattern matches the spec cycle for cycle.
- Reset mid-frame: assert reset during data bit 3 of 0x3C with a second byte pending → next cycle out=1, ready=1, busy=0, done never pulses, and the pending byte is never sent.
  - A following send of 0x81 transmits correctly.
- Parity: PARITY_EN=1, PARITY_ODD=0, send 0x07 → parity bit 1; frame is 11 cycles.
  - With PARITY_ODD=1 the parity bit is 0.
- Loopback: drive `out` into the existing serial receiver's `in` with 50 random bytes, back-to-back and with random gaps → receiver done asserts once per frame and it never enters its error state.
